// File: rtl/carry_select_adder_pkg.sv
// Shared constants and helpers for the carry-select adder.
//   DefaultWidth : default operand width in bits
//   DefaultBlk   : default carry-select block size in bits
//   num_blocks() : number of carry-select blocks, ceil(width / blk)
package carry_select_adder_pkg;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned DefaultBlk   = 2;

  function automatic int unsigned num_blocks(input int unsigned width, input int unsigned blk);
    return (width + blk - 1) / blk;
  endfunction

endpackage

// File: rtl/carry_select_adder_rca_block.sv
// Ripple-carry adder block: {co, s} = a + b + ci.
// Ports:
//   a, b : W-bit addends
//   ci   : carry in
//   s    : W-bit sum
//   co   : carry out
module rca_block #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic carry;

  always_comb begin
    carry = ci;
    s     = '0;
    for (int i = 0; i < int'(W); i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

  assign co = carry;

endmodule

// File: rtl/carry_select_adder.sv
// Registered carry-select adder: {cout, sum} = a + b + cin, one cycle latency.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : a/b/cin valid this cycle
//   a, b      : WIDTH-bit unsigned operands
//   cin       : carry in
//   sum       : registered WIDTH-bit sum
//   cout      : registered carry out
//   out_valid : sum/cout hold the result of a valid input
module carry_select_adder
  import carry_select_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned BLK   = DefaultBlk
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  localparam int unsigned NBLK = num_blocks(WIDTH, BLK);

  logic [WIDTH-1:0] sum_comb;
  // carry[k] is the carry into block k; carry[NBLK] is the final carry out.
  logic             carry [NBLK+1];

  assign carry[0] = cin;

  for (genvar k = 0; k < int'(NBLK); k++) begin : g_blk
    localparam int unsigned Idx = k;
    localparam int unsigned Lo  = Idx * BLK;
    // The top block takes whatever bits remain.
    localparam int unsigned W   = (Idx == NBLK - 1) ? WIDTH - Lo : BLK;

    if (k == 0) begin : g_ripple
      rca_block #(.W(W)) u_rca (
        .a  (a[Lo +: W]),
        .b  (b[Lo +: W]),
        .ci (carry[0]),
        .s  (sum_comb[Lo +: W]),
        .co (carry[1])
      );
    end else begin : g_select
      logic [W-1:0] s0;
      logic [W-1:0] s1;
      logic         co0;
      logic         co1;

      rca_block #(.W(W)) u_rca0 (
        .a  (a[Lo +: W]),
        .b  (b[Lo +: W]),
        .ci (1'b0),
        .s  (s0),
        .co (co0)
      );

      rca_block #(.W(W)) u_rca1 (
        .a  (a[Lo +: W]),
        .b  (b[Lo +: W]),
        .ci (1'b1),
        .s  (s1),
        .co (co1)
      );

      assign sum_comb[Lo +: W] = carry[k] ? s1 : s0;
      assign carry[k+1]        = carry[k] ? co1 : co0;
    end
  end

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_comb;
        cout_q <= carry[NBLK];
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_carry_select_adder.sv
// Self-checking bench for carry_select_adder: WIDTH=4/BLK=2 and WIDTH=8/BLK=3 instances.
module tb_carry_select_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic       in_valid4;
  logic [3:0] a4, b4, sum4;
  logic       cin4, cout4, ov4;

  logic       in_valid8;
  logic [7:0] a8, b8, sum8;
  logic       cin8, cout8, ov8;

  int n_cmp = 0;
  int n_err = 0;

  carry_select_adder #(.WIDTH(4), .BLK(2)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
    .sum       (sum4),
    .cout      (cout4),
    .out_valid (ov4)
  );

  carry_select_adder #(.WIDTH(8), .BLK(3)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .sum       (sum8),
    .cout      (cout8),
    .out_valid (ov8)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Drive one vector at a falling edge, check {out_valid,cout,sum} one cycle later.
  task automatic vec4(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic c, input logic [4:0] exp);
    @(negedge clk);
    a4 = a; b4 = b; cin4 = c; in_valid4 = 1'b1;
    @(negedge clk);
    check(tag, {10'd0, ov4, cout4, sum4}, {10'd0, 1'b1, exp});
  endtask

  task automatic vec8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [8:0] exp);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1;
    @(negedge clk);
    check(tag, {6'd0, ov8, cout8, sum8}, {6'd0, 1'b1, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] prev_exp;
    bit         have_prev;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] re;

    rst_n = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;

    #2;
    check("reset4", {10'd0, ov4, cout4, sum4}, 16'd0);
    check("reset8", {6'd0, ov8, cout8, sum8}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive back-to-back sweep.
    have_prev = 1'b0;
    prev_exp  = '0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 256; i++) begin
        @(negedge clk);
        if (have_prev) check("sweep", {10'd0, ov4, cout4, sum4}, {10'd0, 1'b1, prev_exp});
        a4 = 4'(i >> 4);
        b4 = 4'(i);
        cin4 = c[0];
        in_valid4 = 1'b1;
        prev_exp = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
        have_prev = 1'b1;
      end
    end
    @(negedge clk);
    check("sweep_last", {10'd0, ov4, cout4, sum4}, {10'd0, 1'b1, prev_exp});

    vec4("carry_f0",  4'hF, 4'h0, 1'b1, 5'h10);
    vec4("all_ones",  4'hF, 4'hF, 1'b1, 5'h1F);
    vec4("zeros",     4'h0, 4'h0, 1'b0, 5'h00);
    vec4("boundary",  4'h3, 4'h1, 1'b0, 5'h04);
    vec4("valid_on",  4'h5, 4'h6, 1'b0, 5'h0B);

    @(negedge clk);
    in_valid4 = 1'b0; a4 = 4'h1; b4 = 4'h1; cin4 = 1'b0;
    @(negedge clk);
    check("valid_off", {10'd0, ov4, cout4, sum4}, {10'd0, 1'b0, 1'b0, 4'hB});

    // Async reset between edges, with a valid input in flight.
    vec4("pre_reset", 4'h9, 4'h4, 1'b0, 5'h0D);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst4", {10'd0, ov4, cout4, sum4}, 16'd0);
    check("async_rst8", {6'd0, ov8, cout8, sum8}, 16'd0);
    #1 rst_n = 1'b1;
    in_valid4 = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {10'd0, ov4, cout4, sum4}, 16'd0);
    vec4("post_rst", 4'h2, 4'h2, 1'b0, 5'h04);

    // WIDTH=8, BLK=3: block boundaries at bits 3 and 6.
    vec8("w8_ff_01",  8'hFF, 8'h01, 1'b0, 9'h100);
    vec8("w8_blk0",   8'h07, 8'h01, 1'b0, 9'h008);
    vec8("w8_blk1",   8'h3F, 8'h00, 1'b1, 9'h040);
    vec8("w8_ones",   8'hFF, 8'hFF, 1'b1, 9'h1FF);
    vec8("w8_mixed",  8'hA5, 8'h5A, 1'b1, 9'h100);
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      re = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      vec8("w8_rand", ra, rb, rc, re);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
